tcpc_tx_protocol: RTL

//  Parametrised USB-PD protocol-layer transmit engine for the TCPC. Takes a TRANSMIT request
//  (SOP type + retry count) from the register block, drives the PHY, runs the CRCReceive timer,

---
 rtl/tcpc_pkg.sv | 30 +++
 rtl/tcpc_crc_timer.sv | 38 +++
 rtl/tcpc_tx_protocol.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/tcpc_pkg.sv
// Shared encodings for the TCPC protocol-layer transmit path: FSM states,
// SOP type codes and the MessageID width.
package tcpc_pkg;

    localparam int MSGID_W = 3;
    localparam int SOP_W   = 3;

    localparam logic [SOP_W-1:0] SOP_SOP        = 3'd0;
    localparam logic [SOP_W-1:0] SOP_PRIME      = 3'd1;
    localparam logic [SOP_W-1:0] SOP_DPRIME     = 3'd2;
    localparam logic [SOP_W-1:0] SOP_DBG_PRIME  = 3'd3;
    localparam logic [SOP_W-1:0] SOP_DBG_DPRIME = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONSTRUCT,
        S_WAIT_CRC,
        S_MATCH,
        S_CHECK_RETRY,
        S_REPORT_SUCCESS,
        S_REPORT_FAIL,
        S_REPORT_DISCARD
    } tx_state_e;

    typedef struct packed {
        logic [SOP_W-1:0]   sop;
        logic [MSGID_W-1:0] msgid;
    } goodcrc_t;

endpackage

// File: rtl/tcpc_crc_timer.sv
// CRCReceive timer: counts while enabled, returns to zero while cleared and
// flags the last cycle of the allowed GoodCRC window.
module tcpc_crc_timer #(
    parameter int TIMER_W     = 16,
    parameter int CRC_TIMEOUT = 900
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic en_i,
    output logic timeout_o
);

    logic [TIMER_W-1:0] cnt_q;
    logic [TIMER_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + TIMER_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout_o = en_i && (cnt_q == TIMER_W'(CRC_TIMEOUT - 1));

endmodule

// File: rtl/tcpc_tx_protocol.sv
// USB-PD protocol-layer transmit engine: runs one TRANSMIT request through
// PHY send, GoodCRC wait/match and retries, and keeps per-SOP MessageIDCounters.
module tcpc_tx_protocol
    import tcpc_pkg::*;
#(
    parameter int N_SOP       = 3,
    parameter int MAX_RETRY   = 3,
    parameter int TIMER_W     = 16,
    parameter int CRC_TIMEOUT = 900
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               tx_req_i,
    input  logic [SOP_W-1:0]   tx_sop_i,
    input  logic [1:0]         tx_retry_i,
    input  logic               msgid_clr_i,
    input  logic               phy_sent_i,
    input  logic               phy_discarded_i,
    input  logic               rx_goodcrc_vld_i,
    input  logic [SOP_W-1:0]   rx_goodcrc_sop_i,
    input  logic [MSGID_W-1:0] rx_goodcrc_msgid_i,
    output logic               pass_bytes_o,
    output logic [MSGID_W-1:0] tx_msgid_o,
    output logic               tx_busy_o,
    output logic               alert_success_o,
    output logic               alert_failed_o,
    output logic               alert_discarded_o
);

    localparam int RETRY_W = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);

    tx_state_e           state_q, state_d;
    logic [SOP_W-1:0]    sop_q, sop_d;
    logic [RETRY_W-1:0]  retry_q, retry_d;
    logic [RETRY_W-1:0]  retry_cnt_q, retry_cnt_d;
    logic [MSGID_W-1:0]  msgid_q, msgid_d;
    goodcrc_t            crc_q, crc_d;
    logic                alert_success_q, alert_failed_q, alert_discarded_q;

    logic [MSGID_W-1:0]  msgid_cnt_q [N_SOP];
    logic [MSGID_W-1:0]  msgid_sel;
    logic [RETRY_W-1:0]  retry_clamped;
    logic                req_sop_valid;
    logic                latched_sop_valid;
    logic                msgid_inc;
    logic                crc_timeout;

    assign req_sop_valid     = int'(tx_sop_i) < N_SOP;
    assign latched_sop_valid = int'(sop_q) < N_SOP;

    always_comb begin
        retry_clamped = RETRY_W'(tx_retry_i);
        if (int'(tx_retry_i) > MAX_RETRY) begin
            retry_clamped = RETRY_W'(MAX_RETRY);
        end
    end

    always_comb begin
        msgid_sel = '0;
        for (int i = 0; i < N_SOP; i++) begin
            if (tx_sop_i == SOP_W'(i)) begin
                msgid_sel = msgid_cnt_q[i];
            end
        end
    end

    tcpc_crc_timer #(
        .TIMER_W     (TIMER_W),
        .CRC_TIMEOUT (CRC_TIMEOUT)
    ) u_crc_timer (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .clear_i   (state_q != S_WAIT_CRC),
        .en_i      (state_q == S_WAIT_CRC),
        .timeout_o (crc_timeout)
    );

    // NOTE: every variable gets its hold value before the case statement, so no
    // path through the decode can infer a latch.
    always_comb begin
        state_d     = state_q;
        sop_d       = sop_q;
        retry_d     = retry_q;
        retry_cnt_d = retry_cnt_q;
        msgid_d     = msgid_q;
        crc_d       = crc_q;
        unique case (state_q)
            S_IDLE: begin
                if (tx_req_i) begin
                    sop_d       = tx_sop_i;
                    retry_d     = retry_clamped;
                    retry_cnt_d = '0;
                    msgid_d     = req_sop_valid ? msgid_sel : '0;
                    state_d     = req_sop_valid ? S_CONSTRUCT : S_REPORT_FAIL;
                end
            end
            S_CONSTRUCT: begin
                if (phy_discarded_i) begin
                    state_d = S_REPORT_DISCARD;
                end else if (phy_sent_i) begin
                    state_d = S_WAIT_CRC;
                end
            end
            S_WAIT_CRC: begin
                // A GoodCRC arriving on the timeout cycle still counts.
                if (rx_goodcrc_vld_i) begin
                    crc_d   = '{sop: rx_goodcrc_sop_i, msgid: rx_goodcrc_msgid_i};
                    state_d = S_MATCH;
                end else if (crc_timeout || phy_discarded_i) begin
                    state_d = S_CHECK_RETRY;
                end
            end
            S_MATCH: begin
                if ((crc_q.sop == sop_q) && (crc_q.msgid == msgid_q)) begin
                    state_d = S_REPORT_SUCCESS;
                end else begin
                    state_d = S_CHECK_RETRY;
                end
            end
            S_CHECK_RETRY: begin
                if (retry_cnt_q == retry_q) begin
                    state_d = S_REPORT_FAIL;
                end else begin
                    retry_cnt_d = retry_cnt_q + RETRY_W'(1);
                    state_d     = S_CONSTRUCT;
                end
            end
            S_REPORT_SUCCESS, S_REPORT_FAIL, S_REPORT_DISCARD: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q           <= S_IDLE;
            sop_q             <= '0;
            retry_q           <= '0;
            retry_cnt_q       <= '0;
            msgid_q           <= '0;
            crc_q             <= '0;
            alert_success_q   <= 1'b0;
            alert_failed_q    <= 1'b0;
            alert_discarded_q <= 1'b0;
        end else begin
            state_q           <= state_d;
            sop_q             <= sop_d;
            retry_q           <= retry_d;
            retry_cnt_q       <= retry_cnt_d;
            msgid_q           <= msgid_d;
            crc_q             <= crc_d;
            alert_success_q   <= (state_d == S_REPORT_SUCCESS);
            alert_failed_q    <= (state_d == S_REPORT_FAIL);
            alert_discarded_q <= (state_d == S_REPORT_DISCARD);
        end
    end

    // Rejected SOP codes have no counter, so a failed report for them bumps nothing.
    assign msgid_inc = latched_sop_valid &&
                       ((state_q == S_REPORT_SUCCESS) || (state_q == S_REPORT_FAIL));

    // NOTE: the counter array is architecturally visible and must start at zero,
    // so unlike a data buffer it is reset.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < N_SOP; i++) begin
                msgid_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_SOP; i++) begin
                if (msgid_clr_i) begin
                    msgid_cnt_q[i] <= '0;
                end else if (msgid_inc && (sop_q == SOP_W'(i))) begin
                    msgid_cnt_q[i] <= msgid_cnt_q[i] + MSGID_W'(1);
                end
            end
        end
    end

    assign pass_bytes_o      = (state_q == S_CONSTRUCT);
    assign tx_busy_o         = (state_q != S_IDLE);
    assign tx_msgid_o        = msgid_q;
    assign alert_success_o   = alert_success_q;
    assign alert_failed_o    = alert_failed_q;
    assign alert_discarded_o = alert_discarded_q;

endmodule
